// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush/halt sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// It watches the ID and EX stages and drives the PC and pipeline-register
// write enables, the bubble inserts and the jump-target select. It also
// raises `halted` once every instruction older than HALT has written back.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   id_*              ID-stage instruction info (valid, sources, HALT)
//   ex_*              EX-stage instruction info (valid, load, dest, taken jump)
//   pc_write_en       PC may update
//   if_id_write_en    IF/ID register may load
//   if_id_flush       IF/ID loads a bubble
//   id_ex_flush       ID/EX loads a bubble
//   pc_sel_jump       PC mux selects the EX jump target
//   halted            processor stopped, register file stable
//   stall_count       load-use stall cycles (HAZARD_PERF_CNT_EN only, else 0)
//   flush_count       squashed instruction slots (HAZARD_PERF_CNT_EN only, else 0)
//
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// performance counters. When it is undefined no counter flops exist and
// both count ports are tied to zero.
//
// state   | meaning
// RUN     | normal issue; load-use stalls and jump flushes are handled here
// DRAIN   | HALT has left ID; older instructions are finishing
// HALTED  | everything has retired; held until RST
module pipeline_hazard_ctrl #(
  parameter int RegAddrBits = 3,
  parameter int FlushDepth  = 2,
  parameter int DrainCycles = 3,
  parameter int CntWidth    = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   id_valid,
  input  logic [RegAddrBits-1:0] id_rs,
  input  logic [RegAddrBits-1:0] id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_is_halt,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic [RegAddrBits-1:0] ex_rd,
  input  logic                   ex_jump_taken,
  output logic                   pc_write_en,
  output logic                   if_id_write_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   pc_sel_jump,
  output logic                   halted,
  output logic [CntWidth-1:0]    stall_count,
  output logic [CntWidth-1:0]    flush_count
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  localparam int DW = $clog2(DrainCycles + 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            load_use;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = ex_valid && ex_is_load && id_valid && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state. HALT only enters DRAIN when neither a jump (HALT on the
  // wrong path) nor a load-use stall (HALT must wait in ID) is active.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!ex_jump_taken && !load_use && id_valid && id_is_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DW'(DrainCycles);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DW'(1)) begin
          state_d     = ST_HALTED;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  // Outputs. While RST is high the pipeline free-runs with no bubbles.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    pc_sel_jump    = 1'b0;
    halted         = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_RUN: begin
          if (ex_jump_taken) begin
            // Squash the younger slots: IF/ID first, then ID/EX.
            pc_sel_jump = 1'b1;
            if_id_flush = (FlushDepth >= 1);
            id_ex_flush = (FlushDepth >= 2);
          end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
          end else if (id_valid && id_is_halt) begin
            // HALT moves on into EX as a no-op; nothing behind it advances.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
          end
        end
        ST_DRAIN: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          if_id_flush    = 1'b1;
        end
        default: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          if_id_flush    = 1'b1;
          id_ex_flush    = 1'b1;
          halted         = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
  logic [CntWidth-1:0] flush_cnt_q, flush_cnt_d;
  logic [CntWidth:0]   flush_sum;

  assign flush_sum = {1'b0, flush_cnt_q} + (CntWidth + 1)'(FlushDepth);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == ST_RUN) begin
      if (ex_jump_taken) begin
        flush_cnt_d = flush_sum[CntWidth] ? '1 : flush_sum[CntWidth-1:0];
      end else if (load_use && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int RB    = 3;
  localparam int CW    = 16;
  localparam int DRAIN = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          id_valid, id_uses_rs, id_uses_rt, id_is_halt;
  logic [RB-1:0] id_rs, id_rt, ex_rd;
  logic          ex_valid, ex_is_load, ex_jump_taken;
  logic          pc_write_en, if_id_write_en, if_id_flush, id_ex_flush;
  logic          pc_sel_jump, halted;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.RegAddrBits(RB), .FlushDepth(2), .DrainCycles(DRAIN), .CntWidth(CW)) dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_halt(id_is_halt),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_jump_taken(ex_jump_taken),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_sel_jump(pc_sel_jump), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: m_age < 0 means running; otherwise the number of clock
  // edges since HALT was accepted (1..DRAIN draining, beyond that halted).
  int m_age;
  int m_stall, m_flush;

  function automatic bit m_load_use();
    if (!(ex_valid && ex_is_load && id_valid) || ex_rd == 0) return 1'b0;
    return (id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd);
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit e_pc, e_ifid, e_iff, e_idf, e_sel, e_h;
    int e_stall, e_flush;
    e_pc = 1; e_ifid = 1; e_iff = 0; e_idf = 0; e_sel = 0; e_h = 0;
    if (!RST) begin
      if (m_age < 0) begin
        if (ex_jump_taken) begin
          e_sel = 1; e_iff = 1; e_idf = 1;
        end else if (m_load_use()) begin
          e_pc = 0; e_ifid = 0; e_idf = 1;
        end else if (id_valid && id_is_halt) begin
          e_pc = 0; e_ifid = 0;
        end
      end else if (m_age <= DRAIN) begin
        e_pc = 0; e_ifid = 0; e_iff = 1;
      end else begin
        e_pc = 0; e_ifid = 0; e_iff = 1; e_idf = 1; e_h = 1;
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    e_stall = m_stall; e_flush = m_flush;
`else
    e_stall = 0; e_flush = 0;
`endif
    chk("pc_write_en",    CW'(pc_write_en),    CW'(e_pc));
    chk("if_id_write_en", CW'(if_id_write_en), CW'(e_ifid));
    chk("if_id_flush",    CW'(if_id_flush),    CW'(e_iff));
    chk("id_ex_flush",    CW'(id_ex_flush),    CW'(e_idf));
    chk("pc_sel_jump",    CW'(pc_sel_jump),    CW'(e_sel));
    chk("halted",         CW'(halted),         CW'(e_h));
    chk("stall_count",    stall_count,         CW'(e_stall));
    chk("flush_count",    flush_count,         CW'(e_flush));
  endtask

  // Check this cycle's outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    @(negedge CLK);
    #1;
    check_outputs();
    @(posedge CLK);
    if (RST) begin
      m_age = -1; m_stall = 0; m_flush = 0;
    end else if (m_age < 0) begin
      if (ex_jump_taken) m_flush = (m_flush + 2 > CMAX) ? CMAX : m_flush + 2;
      else if (m_load_use()) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
      else if (id_valid && id_is_halt) m_age = 1;
    end else if (m_age < 1000) begin
      m_age++;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_halt = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_jump_taken = 0;
  endtask

  task automatic set_load_use(input logic [RB-1:0] rd, input logic [RB-1:0] rs,
                              input logic [RB-1:0] rt, input bit urs, input bit urt);
    idle();
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
  endtask

  initial begin
    m_age = -1; m_stall = 0; m_flush = 0;
    RST = 1; idle();
    cycle(); cycle();
    RST = 0;
    cycle();

    // LW $2 followed by ADD $3,$2,$2: one stall, then the bubble in EX clears it
    set_load_use(3'd2, 3'd2, 3'd2, 1, 1); cycle();
    ex_valid = 0; cycle();
    // Load into $0 and an instruction without sources never stall
    set_load_use(3'd0, 3'd0, 3'd0, 1, 1); cycle();
    set_load_use(3'd2, 3'd2, 3'd2, 0, 0); cycle();
    // rt-only and rs-only matches
    set_load_use(3'd5, 3'd1, 3'd5, 1, 1); cycle();
    ex_valid = 0; cycle();
    set_load_use(3'd7, 3'd7, 3'd4, 1, 0); cycle();
    idle(); cycle();

    // Lone taken jump, then jump + load-use + HALT together
    ex_jump_taken = 1; cycle();
    idle(); cycle();
    set_load_use(3'd3, 3'd3, 3'd0, 1, 0); id_is_halt = 1; ex_jump_taken = 1; cycle();
    idle(); cycle();
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_count_total", stall_count, CW'(3));
    chk("flush_count_total", flush_count, CW'(4));
`else
    chk("stall_count_total", stall_count, CW'(0));
    chk("flush_count_total", flush_count, CW'(0));
`endif

    // HALT held behind a load-use stall, then entry once the bubble is in EX
    set_load_use(3'd4, 3'd4, 3'd0, 1, 0); id_is_halt = 1; cycle();
    ex_valid = 0; cycle();
    // Jumps during DRAIN and hazards in HALTED are ignored
    idle(); ex_jump_taken = 1;
    for (int i = 0; i < DRAIN; i++) cycle();
    set_load_use(3'd1, 3'd1, 3'd1, 1, 1); id_is_halt = 1; ex_jump_taken = 1;
    for (int i = 0; i < 3; i++) cycle();
    // One reset cycle brings everything back to RUN
    idle(); RST = 1; cycle();
    RST = 0; cycle();
    set_load_use(3'd6, 3'd6, 3'd0, 1, 0); cycle();

    // Randomized traffic with small register range for frequent matches
    for (int n = 0; n < 600; n++) begin
      RST           = ($urandom_range(0, 39) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs         = RB'($urandom_range(0, 3));
      id_rt         = RB'($urandom_range(0, 3));
      id_uses_rs    = $urandom_range(0, 1);
      id_uses_rt    = $urandom_range(0, 1);
      id_is_halt    = ($urandom_range(0, 24) == 0);
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_is_load    = $urandom_range(0, 1);
      ex_rd         = RB'($urandom_range(0, 3));
      ex_jump_taken = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
